// File: rtl/ode_ram_pkg.sv
// Shared constants and types for the ODE solver RAM banks and their port arbiters.
package ode_ram_pkg;

  localparam int unsigned DATA_WIDTH = 64;

  // Per-bank geometry: U/T, A, B and X/H banks
  localparam int unsigned UT_ADDRESS_HEIGHT = 918;
  localparam int unsigned UT_ADDRESS_WIDTH  = 10;
  localparam int unsigned A_ADDRESS_HEIGHT  = 2500;
  localparam int unsigned A_ADDRESS_WIDTH   = 12;
  localparam int unsigned B_ADDRESS_HEIGHT  = 2500;
  localparam int unsigned B_ADDRESS_WIDTH   = 12;
  localparam int unsigned XH_ADDRESS_HEIGHT = 69;
  localparam int unsigned XH_ADDRESS_WIDTH  = 7;

  localparam int unsigned NUM_REQ      = 3;
  localparam int unsigned REQ_LOADER   = 0;
  localparam int unsigned REQ_SOLVER   = 1;
  localparam int unsigned REQ_UNLOADER = 2;

  typedef enum logic {
    ARB,
    OWNED
  } arb_state_e;

  // Next requester index in the 0 -> 1 -> 2 -> 0 rotation
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three requesters, starting the search at ptr.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic [1:0] index
);

  logic [5:0] req_dbl;
  logic [2:0] req_rot;
  logic [1:0] offset;
  logic [2:0] sum;

  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: 3];
    grant   = '0;
    index   = '0;
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else                 offset = 2'd2;
    sum = 3'(ptr) + 3'(offset);
    if (|req) begin
      index = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      grant = 3'b001 << index;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one solver RAM bank port among three requesters.
// Define RAM_ARB_RANGE_CHECK_EN to suppress and flag accesses at or beyond ADDRESS_HEIGHT.
module ram_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = ode_ram_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = ode_ram_pkg::A_ADDRESS_WIDTH,
  parameter int unsigned ADDRESS_HEIGHT = ode_ram_pkg::A_ADDRESS_HEIGHT,
  parameter int unsigned MAX_BURST      = 50
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 req,
  input  logic [2:0]                 req_wr,
  input  logic [2:0]                 req_lock,
  input  logic [3*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0]    req_wdata,
  output logic [2:0]                 gnt,
  output logic [2:0]                 rvalid,
  output logic [2:0]                 rerr,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ADDRESS_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]      data_write,
  output logic                       WR_signal,
  input  logic [DATA_WIDTH-1:0]      data_read
);
  import ode_ram_pkg::*;

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

`ifdef RAM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [BW-1:0] cnt_q, cnt_d;

  logic [2:0] pick_gnt;
  logic [1:0] pick_idx;
  logic [1:0] pick_ptr;
  logic       owned_hit;
  logic [1:0] sel;
  logic       sel_vld;
  logic       oor;

  logic [ADDRESS_WIDTH-1:0] addr_a  [3];
  logic [DATA_WIDTH-1:0]    wdata_a [3];
  logic [ADDRESS_WIDTH-1:0] sel_addr;

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A released owner hands the search start to its successor in the same cycle
  assign pick_ptr  = (state_q == OWNED) ? rr_next(owner_q) : ptr_q;
  assign owned_hit = (state_q == OWNED) && req[owner_q] && (cnt_q < BW'(MAX_BURST));

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .grant (pick_gnt),
    .index (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel     = pick_idx;
    sel_vld = |req;
    gnt     = '0;

    if (owned_hit) begin
      sel     = owner_q;
      sel_vld = 1'b1;
      cnt_d   = cnt_q + BW'(1);
      if (!req_lock[owner_q] || cnt_d == BW'(MAX_BURST)) begin
        state_d = ARB;
        ptr_d   = rr_next(owner_q);
        cnt_d   = '0;
      end
    end else begin
      if (state_q == OWNED) begin
        state_d = ARB;
        ptr_d   = rr_next(owner_q);
        cnt_d   = '0;
      end
      if (sel_vld) begin
        if (req_lock[pick_idx]) begin
          state_d = OWNED;
          owner_d = pick_idx;
          cnt_d   = BW'(1);
        end else begin
          ptr_d = rr_next(pick_idx);
        end
      end
    end

    if (rst) sel_vld = 1'b0;
    if (sel_vld) gnt = owned_hit ? (3'b001 << owner_q) : pick_gnt;
  end

  // Bank port drive; out-of-range accesses are consumed but never reach the bank
  assign sel_addr   = addr_a[sel];
  assign oor        = RANGE_CHECK && sel_vld && (32'(sel_addr) >= ADDRESS_HEIGHT);
  assign address    = (sel_vld && !oor) ? sel_addr : '0;
  assign data_write = sel_vld ? wdata_a[sel] : '0;
  assign WR_signal  = sel_vld && req_wr[sel] && !oor;
  assign rdata      = data_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rvalid  <= '0;
      rerr    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rvalid  <= gnt & ~req_wr;
      rerr    <= oor ? gnt : 3'b000;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: scripted scenarios plus randomized traffic against a reference model.
module tb_ram_port_arbiter;
  import ode_ram_pkg::*;

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = 12;
  localparam int          AH    = 69;
  localparam int          MB    = 4;
  localparam int          DEPTH = 1 << AW;

`ifdef RAM_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [2:0] req, req_wr, req_lock;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0] gnt, rvalid, rerr;
  logic [DW-1:0] rdata, data_write, data_read;
  logic [AW-1:0] address;
  logic WR_signal;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ADDRESS_HEIGHT(AH), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rerr(rerr), .rdata(rdata), .address(address), .data_write(data_write),
    .WR_signal(WR_signal), .data_read(data_read)
  );

  function automatic logic [DW-1:0] seed_word(input int i);
    return {32'(i) * 32'h9E37_79B9, ~32'(i) ^ 32'h5A5A_1234};
  endfunction

  // Bank with one-cycle registered read
  logic [DW-1:0] bank [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) bank[i] = seed_word(i);
    forever begin
      @(posedge clk);
      if (WR_signal) bank[address] <= data_write;
      data_read <= bank[address];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_owner, m_cnt, m_ptr;
  logic [DW-1:0] ref_mem [DEPTH];
  int e_idx;
  logic e_oor, e_wr;
  logic [2:0] e_gnt, e_rvalid, e_rerr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  function automatic int m_pick();
    int p;
    if (rst) return -1;
    if (m_owner >= 0 && req[m_owner] && m_cnt < MB) return m_owner;
    p = (m_owner >= 0) ? (m_owner + 1) % 3 : m_ptr;
    for (int k = 0; k < 3; k++) if (req[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic drive(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic eval_cycle();
    logic [AW-1:0] a;
    @(negedge clk);
    e_idx = m_pick();
    e_gnt = '0; e_wr = 1'b0; e_addr = '0; e_wdata = '0; e_oor = 1'b0;
    if (e_idx >= 0) begin
      a        = req_addr[e_idx*AW +: AW];
      e_oor    = RC && (int'(a) >= AH);
      e_gnt[e_idx] = 1'b1;
      e_wr     = req_wr[e_idx] && !e_oor;
      e_addr   = e_oor ? '0 : a;
      e_wdata  = req_wdata[e_idx*DW +: DW];
    end
  endtask

  task automatic end_cycle();
    logic [2:0] nv, ne;
    logic [DW-1:0] nd;
    logic hit;
    nv = '0; ne = '0; nd = e_rdata;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0;
    end else begin
      if (e_idx >= 0) begin
        if (!req_wr[e_idx]) begin nv[e_idx] = 1'b1; nd = ref_mem[e_addr]; end
        if (e_oor) ne[e_idx] = 1'b1;
        else if (req_wr[e_idx]) ref_mem[e_addr] = e_wdata;
      end
      hit = m_owner >= 0 && req[m_owner] && m_cnt < MB;
      if (hit) begin
        m_cnt++;
        if (!req_lock[m_owner] || m_cnt == MB) begin
          m_ptr = (m_owner + 1) % 3; m_owner = -1; m_cnt = 0;
        end
      end else begin
        if (m_owner >= 0) begin m_ptr = (m_owner + 1) % 3; m_owner = -1; m_cnt = 0; end
        if (e_idx >= 0) begin
          if (req_lock[e_idx]) begin m_owner = e_idx; m_cnt = 1; end
          else m_ptr = (e_idx + 1) % 3;
        end
      end
    end
    @(posedge clk); #1;
    e_rvalid = nv; e_rerr = ne; e_rdata = nd;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    m_owner = -1; m_cnt = 0; m_ptr = 0; e_rvalid = '0; e_rerr = '0; e_rdata = '0;
    req = 3'b111; req_wr = 3'b010;
    for (int c = 0; c < 2; c++) begin
      eval_cycle();
      checks++;
      if ({gnt, WR_signal, address, data_write} !== {3'b000, 1'b0, AW'(0), DW'(0)}) begin
        errors++;
        $display("FAIL reset_port c%0d: got gnt=%b wr=%b addr=%h wdata=%h, exp all zero", c, gnt, WR_signal, address, data_write);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL reset_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      end_cycle();
    end
    rst = 1'b0; req = '0; req_wr = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
    for (int i = 0; i < 3; i++) drive(i, 1'b0, AW'($urandom_range(AH - 1)), '0);
    req_lock = '0;
    for (int c = 0; c < 6; c++) begin
      req = (c < 5) ? 3'b111 : 3'b000;
      eval_cycle();
      checks++;
      if (gnt !== seq[c]) begin
        errors++;
        $display("FAIL rr_order c%0d: got gnt=%b, exp %b", c, gnt, seq[c]);
      end
      checks++;
      if ({gnt, WR_signal, address, data_write} !== {e_gnt, e_wr, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL rr_port c%0d: got gnt=%b wr=%b addr=%h wdata=%h, exp gnt=%b wr=%b addr=%h wdata=%h",
                 c, gnt, WR_signal, address, data_write, e_gnt, e_wr, e_addr, e_wdata);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL rr_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      if (e_rvalid != '0 && e_rerr == '0) begin
        checks++;
        if (rdata !== e_rdata) begin
          errors++;
          $display("FAIL rr_rdata c%0d: got %h, exp %h", c, rdata, e_rdata);
        end
      end
      end_cycle();
      if (e_idx >= 0) drive(e_idx, 1'b0, AW'($urandom_range(AH - 1)), '0);
    end
  endtask

  task automatic test_write_read();
    logic [2:0] t_req [4] = '{3'b010, 3'b001, 3'b000, 3'b000};
    logic [2:0] t_wr  [4] = '{3'b010, 3'b000, 3'b000, 3'b000};
    drive(1, 1'b1, AW'(7), DW'(64'hDEAD_BEEF));
    drive(0, 1'b0, AW'(7), '0);
    req_lock = '0;
    for (int c = 0; c < 4; c++) begin
      req = t_req[c]; req_wr = t_wr[c];
      eval_cycle();
      checks++;
      if ({gnt, WR_signal, address, data_write} !== {e_gnt, e_wr, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL wrrd_port c%0d: got gnt=%b wr=%b addr=%h wdata=%h, exp gnt=%b wr=%b addr=%h wdata=%h",
                 c, gnt, WR_signal, address, data_write, e_gnt, e_wr, e_addr, e_wdata);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL wrrd_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      if (c == 2) begin
        checks++;
        if (rvalid !== 3'b001 || rdata !== DW'(64'hDEAD_BEEF)) begin
          errors++;
          $display("FAIL wrrd_data: got rvalid=%b rdata=%h, exp rvalid=001 rdata=%h", rvalid, rdata, DW'(64'hDEAD_BEEF));
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_burst();
    logic [2:0] t_req  [6] = '{3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
    logic [2:0] t_lock [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
    logic [2:0] seq    [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b000};
    for (int i = 0; i < 3; i++) drive(i, 1'b0, AW'($urandom_range(AH - 1)), '0);
    for (int c = 0; c < 6; c++) begin
      req = t_req[c]; req_lock = t_lock[c];
      eval_cycle();
      checks++;
      if (gnt !== seq[c]) begin
        errors++;
        $display("FAIL burst_order c%0d: got gnt=%b, exp %b", c, gnt, seq[c]);
      end
      checks++;
      if ({gnt, WR_signal, address, data_write} !== {e_gnt, e_wr, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL burst_port c%0d: got gnt=%b wr=%b addr=%h, exp gnt=%b wr=%b addr=%h",
                 c, gnt, WR_signal, address, e_gnt, e_wr, e_addr);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL burst_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      end_cycle();
    end
  endtask

  task automatic test_drop();
    logic [2:0] t_req  [5] = '{3'b001, 3'b011, 3'b010, 3'b011, 3'b000};
    logic [2:0] t_lock [5] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [2:0] seq    [5] = '{3'b001, 3'b001, 3'b010, 3'b001, 3'b000};
    for (int c = 0; c < 5; c++) begin
      req = t_req[c]; req_lock = t_lock[c];
      eval_cycle();
      checks++;
      if (gnt !== seq[c] || gnt !== e_gnt) begin
        errors++;
        $display("FAIL drop_order c%0d: got gnt=%b, exp %b", c, gnt, seq[c]);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL drop_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] t_req  [4] = '{3'b100, 3'b100, 3'b111, 3'b000};
    logic [2:0] t_lock [4] = '{3'b100, 3'b100, 3'b000, 3'b000};
    logic       t_rst  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] seq    [4] = '{3'b100, 3'b000, 3'b001, 3'b000};
    for (int c = 0; c < 4; c++) begin
      req = t_req[c]; req_lock = t_lock[c]; rst = t_rst[c];
      eval_cycle();
      checks++;
      if (gnt !== seq[c] || gnt !== e_gnt) begin
        errors++;
        $display("FAIL rstmid_order c%0d: got gnt=%b, exp %b", c, gnt, seq[c]);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL rstmid_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      if (c == 2) begin
        checks++;
        if (rvalid !== 3'b000) begin
          errors++;
          $display("FAIL rstmid_drop: got rvalid=%b, exp 000", rvalid);
        end
      end
      end_cycle();
    end
    rst = 1'b0;
  endtask

  task automatic test_range();
    logic [2:0] t_req [4] = '{3'b010, 3'b001, 3'b000, 3'b000};
    logic [2:0] t_wr  [4] = '{3'b010, 3'b000, 3'b000, 3'b000};
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_word;
    wd = {$urandom, $urandom};
    drive(1, 1'b1, AW'(100), wd);
    drive(0, 1'b0, AW'(100), '0);
    req_lock = '0;
    for (int c = 0; c < 4; c++) begin
      req = t_req[c]; req_wr = t_wr[c];
      eval_cycle();
      checks++;
      if ({gnt, WR_signal, address, data_write} !== {e_gnt, e_wr, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL range_port c%0d: got gnt=%b wr=%b addr=%h, exp gnt=%b wr=%b addr=%h",
                 c, gnt, WR_signal, address, e_gnt, e_wr, e_addr);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL range_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      if (e_rvalid != '0 && e_rerr == '0) begin
        checks++;
        if (rdata !== e_rdata) begin
          errors++;
          $display("FAIL range_rdata c%0d: got %h, exp %h", c, rdata, e_rdata);
        end
      end
      if (c == 0) begin
        checks++;
        if (gnt !== 3'b010 || WR_signal !== !RC || address !== (RC ? AW'(0) : AW'(100))) begin
          errors++;
          $display("FAIL range_wr: got gnt=%b wr=%b addr=%h, exp gnt=010 wr=%b", gnt, WR_signal, address, !RC);
        end
      end
      if (c == 1) begin
        checks++;
        if (rerr !== (RC ? 3'b010 : 3'b000)) begin
          errors++;
          $display("FAIL range_rerr: got %b, exp %b", rerr, RC ? 3'b010 : 3'b000);
        end
      end
      end_cycle();
    end
    exp_word = RC ? seed_word(100) : wd;
    checks++;
    if (bank[100] !== exp_word) begin
      errors++;
      $display("FAIL range_bank: got %h, exp %h", bank[100], exp_word);
    end
  endtask

  task automatic test_random();
    int last;
    last = -1;
    req = '0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(59) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || last == i) begin
          req[i]      = ($urandom_range(3) != 0);
          req_lock[i] = ($urandom_range(2) == 0);
          drive(i, $urandom_range(2) == 0,
                ($urandom_range(7) == 0) ? AW'($urandom_range(127)) : AW'($urandom_range(AH - 1)),
                {$urandom, $urandom});
        end
      end
      eval_cycle();
      checks++;
      if ({gnt, WR_signal, address, data_write} !== {e_gnt, e_wr, e_addr, e_wdata}) begin
        errors++;
        $display("FAIL rand_port c%0d: got gnt=%b wr=%b addr=%h wdata=%h, exp gnt=%b wr=%b addr=%h wdata=%h",
                 c, gnt, WR_signal, address, data_write, e_gnt, e_wr, e_addr, e_wdata);
      end
      checks++;
      if ({rvalid, rerr} !== {e_rvalid, e_rerr}) begin
        errors++;
        $display("FAIL rand_resp c%0d: got rvalid=%b rerr=%b, exp rvalid=%b rerr=%b", c, rvalid, rerr, e_rvalid, e_rerr);
      end
      if (e_rvalid != '0 && e_rerr == '0) begin
        checks++;
        if (rdata !== e_rdata) begin
          errors++;
          $display("FAIL rand_rdata c%0d: got %h, exp %h", c, rdata, e_rdata);
        end
      end
      last = e_idx;
      end_cycle();
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
    test_reset();
    test_round_robin();
    test_write_read();
    test_burst();
    test_drop();
    test_reset_mid();
    test_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
